// File: rtl/v74x139_dual_decoder.sv
// Registered dual 2-to-4 decoder (74x139 equivalent), active-low enables and outputs.
// Optional status flags act1/act2 are present when V74X139_STATUS_EN is defined.
module v74x139_dual_decoder #(
    parameter logic [7:0] RST_VAL = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       G_L1,
    input  logic       G_L2,
    input  logic       A1,
    input  logic       B1,
    input  logic       A2,
    input  logic       B2,
`ifdef V74X139_STATUS_EN
    output logic       act1,
    output logic       act2,
`endif
    output logic [7:0] sel
);

    logic [7:0] sel_q, sel_d;

    // A disabled half (including an unknown select) always yields all-high.
    function automatic logic [3:0] dec2to4(input logic g_l, input logic [1:0] idx);
        logic [3:0] y;
        y = 4'b1111;
        if (!g_l) begin
            case (idx)
                2'b00:   y = 4'b1110;
                2'b01:   y = 4'b1101;
                2'b10:   y = 4'b1011;
                2'b11:   y = 4'b0111;
                default: y = 4'b1111;
            endcase
        end
        return y;
    endfunction

    always_comb begin
        sel_d      = 8'hFF;
        sel_d[3:0] = dec2to4(G_L1, {B1, A1});
        sel_d[7:4] = dec2to4(G_L2, {B2, A2});
    end

    always_ff @(posedge clk) begin
        if (rst) sel_q <= RST_VAL;
        else     sel_q <= sel_d;
    end

    assign sel = sel_q;

`ifdef V74X139_STATUS_EN
    logic act1_q, act1_d;
    logic act2_q, act2_d;

    always_comb begin
        act1_d = ~G_L1;
        act2_d = ~G_L2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act1_q <= 1'b0;
            act2_q <= 1'b0;
        end else begin
            act1_q <= act1_d;
            act2_q <= act2_d;
        end
    end

    assign act1 = act1_q;
    assign act2 = act2_q;
`endif

endmodule

// File: tb/tb_v74x139_dual_decoder.sv
// Scoreboard bench for v74x139_dual_decoder: driver queues expectations due one cycle
// after each vector, monitor pops and compares after every rising edge.
module tb_v74x139_dual_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       G_L1 = 1'b1, G_L2 = 1'b1;
    logic       A1 = 1'b0, B1 = 1'b0, A2 = 1'b0, B2 = 1'b0;
    logic [7:0] sel;
`ifdef V74X139_STATUS_EN
    logic       act1, act2;
`endif

    v74x139_dual_decoder dut (
        .clk  (clk),
        .rst  (rst),
        .G_L1 (G_L1),
        .G_L2 (G_L2),
        .A1   (A1),
        .B1   (B1),
        .A2   (A2),
        .B2   (B2),
`ifdef V74X139_STATUS_EN
        .act1 (act1),
        .act2 (act2),
`endif
        .sel  (sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sel;
        logic       a1;
        logic       a2;
        int         due;
        int         id;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   vec_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every expectation due at this edge is checked against the registered output.
    always @(posedge clk) begin
        #1;
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (e.due != cyc) begin
                n_fail++;
                $display("FAIL vec%0d stale: checked at cycle %0d, required cycle %0d", e.id, cyc, e.due);
            end else if (sel !== e.sel) begin
                n_fail++;
                $display("FAIL vec%0d sel: got %b, expected %b", e.id, sel, e.sel);
            end
`ifdef V74X139_STATUS_EN
            n_cmp++;
            if (act1 !== e.a1 || act2 !== e.a2) begin
                n_fail++;
                $display("FAIL vec%0d act: got act1=%b act2=%b, expected act1=%b act2=%b",
                         e.id, act1, act2, e.a1, e.a2);
            end
            n_cmp++;
            if (act1 !== ~&sel[3:0] || act2 !== ~&sel[7:4]) begin
                n_fail++;
                $display("FAIL vec%0d act_inv: got act1=%b act2=%b, sel=%b", e.id, act1, act2, sel);
            end
`endif
        end
    end

    task automatic drive(input logic r, input logic g1, input logic g2,
                         input logic a1, input logic b1, input logic a2, input logic b2,
                         input logic [7:0] es, input logic ea1, input logic ea2);
        exp_t e;
        @(negedge clk);
        rst  = r;
        G_L1 = g1;
        G_L2 = g2;
        A1   = a1;
        B1   = b1;
        A2   = a2;
        B2   = b2;
        vec_id++;
        e.sel = es;
        e.a1  = ea1;
        e.a2  = ea2;
        e.due = cyc + 1;
        e.id  = vec_id;
        q.push_back(e);
    endtask

    initial begin
        int waited;
        // reset held for several edges while inputs move
        drive(1, 0, 0, 1, 0, 0, 1, 8'hFF, 0, 0);
        drive(1, 0, 0, 1, 1, 1, 1, 8'hFF, 0, 0);
        drive(1, 0, 1, 0, 1, 1, 0, 8'hFF, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 8'hFF, 0, 0);
        // disabled halves ignore unknown selects
        drive(0, 1, 1, 1'bx, 1'bx, 1'bx, 1'bx, 8'b1111_1111, 0, 0);
        // full sweep, both enabled
        drive(0, 0, 0, 0, 0, 0, 0, 8'b1110_1110, 1, 1);
        drive(0, 0, 0, 1, 0, 1, 0, 8'b1101_1101, 1, 1);
        drive(0, 0, 0, 0, 1, 0, 1, 8'b1011_1011, 1, 1);
        drive(0, 0, 0, 1, 1, 1, 1, 8'b0111_0111, 1, 1);
        drive(0, 0, 0, 1, 1, 1, 1, 8'b0111_0111, 1, 1);
        // independent halves
        drive(0, 0, 1, 1, 1, 0, 0, 8'b1111_0111, 1, 0);
        drive(0, 1, 0, 1, 1, 0, 0, 8'b1110_1111, 0, 1);
        // reset mid-stream then resume
        drive(0, 0, 0, 0, 1, 0, 1, 8'b1011_1011, 1, 1);
        drive(1, 0, 0, 0, 1, 0, 1, 8'hFF, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 1, 8'b1011_1011, 1, 1);
        drive(0, 0, 0, 0, 1, 0, 1, 8'b1011_1011, 1, 1);

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/v74x139_dual_decoder.md
Name: v74x139_dual_decoder

Overview:
- Registered dual 2-to-4 line decoder, functionally equivalent to the 74x139.
- Active-low enables and active-low outputs.
- Two independent decoder halves share one clock and one synchronous reset.
- Used as a glue-logic select generator; the eight active-low selects are packed into one 8-bit bus.

Parameters:
- RST_VAL, 8'hFF, value loaded into sel on reset. Default means all selects deasserted.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- G_L1  input  1  active-low enable, decoder 1.
- G_L2  input  1  active-low enable, decoder 2.
- A1  input  1  select LSB, decoder 1.
- B1  input  1  select MSB, decoder 1.
- A2  input  1  select LSB, decoder 2.
- B2  input  1  select MSB, decoder 2.
- sel  output  8  active-low decoded outputs, registered.
  - sel[3:0] = decoder 1 outputs Y0_L..Y3_L.
  - sel[7:4] = decoder 2 outputs Y0_L..Y3_L.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, sel <= RST_VAL (8'hFF). rst has priority over all other inputs.
- Decoder n, per rising edge when rst=0:
  - index = {Bn, An}, with Bn as MSB.
  - If G_Ln=1: all four outputs of that half are registered as 1.
  - If G_Ln=0: the output at position index is 0; the other three are 1.
- Latency: exactly 1 clock from input change to sel. No combinational path from inputs to sel.
- The two halves are fully independent. Each half's enable gates only its own four outputs.
- Enable dominance: when G_Ln=1, the value of An/Bn is irrelevant, including X/Z in simulation. That half registers 4'b1111, never X.
- At most one output per half is low in any cycle; all outputs high is legal.
- No internal state beyond the 8-bit output register.
- Reset mid-operation: sel returns to RST_VAL on the next edge. Decoding resumes on the first edge with rst=0.
- Holding inputs constant holds sel constant; no toggling or glitch on unchanged inputs.

Optional Feature:
- Macro: V74X139_STATUS_EN.
- Defined: two extra output ports are present.
  - act1 (output, 1 bit) = registered ~G_L1.
  - act2 (output, 1 bit) = registered ~G_L2.
  - Both flag that the corresponding half is driving a low select.
  - Same 1-cycle latency as sel; reset to 0.
  - Invariant: act1 = ~&sel[3:0] and act2 = ~&sel[7:4] on every cycle.
- Not defined: the act1/act2 ports and their logic are absent. The remainder of the block is unchanged.

Test Plan:
- Reset: rst=1 for 2 edges with arbitrary inputs -> sel=8'hFF. Hold rst=1 while inputs change -> sel stays 8'hFF.
- Disabled with unknown selects: G_L1=G_L2=1, A1=B1=A2=B2=X -> one edge later sel=8'b1111_1111, no X bits.
- Full decode sweep with G_L1=G_L2=0:
  - {B,A}=00 -> sel=8'b1110_1110.
  - {B,A}=01 (A=1, B=0) -> sel=8'b1101_1101.
  - {B,A}=10 (A=0, B=1) -> sel=8'b1011_1011.
  - {B,A}=11 -> sel=8'b0111_0111.
  - Each result appears exactly 1 cycle after the input change.
- Independent halves: G_L1=0, G_L2=1, A1=1, B1=1, A2=0, B2=0 -> sel=8'b1111_0111. Swap enables with the same selects -> sel=8'b1110_1111.
- Reset mid-stream: sel=8'b1011_1011, then assert rst for 1 edge -> sel=8'hFF. Release rst with inputs unchanged -> next edge sel=8'b1011_1011.
- With V74X139_STATUS_EN defined: G_L1=0, G_L2=1 -> act1=1, act2=0 one cycle later. Reset -> act1=act2=0.
